relobi_mux: RTL and testbench

- Reliable-OBI N-to-1 multiplexer: arbitrates NumSbrPorts TMR-protected OBI subordinate ports onto one manager port.
- Routes in-order responses back to the originating port.
- Counterpart of the reliable demux; used on interconnect crossbar outputs in front of a single target.
- All control state (arbiter pointer, lock, response-route FIFO, counter) is triplicated and majority-voted every cycle.

---
 rtl/relobi_pkg.sv | 58 +++++
 rtl/relobi_mux_rr_arb.sv | 32 +++
 rtl/relobi_mux.sv | 209 ++++++++++++++++++++
 tb/tb_relobi_mux.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relobi_pkg.sv
// Shared definitions for the reliable-OBI interconnect blocks: TMR width,
// fault vector layout, default request/response structs and OBI config.
package relobi_pkg;

    localparam int unsigned TmrWidth    = 3;

    // Positions inside the fault vector
    localparam int unsigned FaultNow    = 0;
    localparam int unsigned FaultSticky = 1;
    localparam int unsigned FaultWidth  = 2;

    localparam int unsigned AddrWidth   = 32;
    localparam int unsigned DataWidth   = 32;
    localparam int unsigned IdWidth     = 2;
    localparam int unsigned EccWidth    = 8;

    typedef struct packed {
        logic UseRReady;
        logic Integrity;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b1, Integrity: 1'b0};

    // Address channel payload; ecc travels untouched through the mux
    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   we;
        logic [DataWidth/8-1:0] be;
        logic [DataWidth-1:0]   wdata;
        logic [IdWidth-1:0]     aid;
        logic [EccWidth-1:0]    ecc;
    } relobi_a_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   rid;
        logic                 err;
        logic [EccWidth-1:0]  ecc;
    } relobi_r_t;

    typedef struct packed {
        logic [TmrWidth-1:0] req;
        logic [TmrWidth-1:0] rready;
        relobi_a_t           a;
    } relobi_req_t;

    typedef struct packed {
        logic [TmrWidth-1:0] gnt;
        logic [TmrWidth-1:0] rvalid;
        relobi_r_t           r;
    } relobi_rsp_t;

    // Index width that stays at least 1 bit for single-entry ranges
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relobi_mux_rr_arb.sv
// One replica of the round-robin arbiter. A locked replica keeps its stored
// selection so a pending (ungranted) request is never switched away from.
module relobi_mux_rr_arb import relobi_pkg::*; #(
    parameter int unsigned NumPorts = 2,
    parameter int unsigned IdxWidth = idx_width(NumPorts)
) (
    input  logic [NumPorts-1:0] i_req,
    input  logic [IdxWidth-1:0] i_rr,
    input  logic                i_lock,
    input  logic [IdxWidth-1:0] i_lsel,
    output logic [IdxWidth-1:0] o_winner,
    output logic                o_valid
);

    // Pick the locked port, else the first requester at or after the pointer
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        if (i_lock) begin
            o_winner = i_lsel;
            o_valid  = (32'(i_lsel) < NumPorts) && i_req[i_lsel];
        end else begin
            for (int unsigned k = 0; k < NumPorts; k++) begin
                if (!o_valid && i_req[IdxWidth'((32'(i_rr) + k) % NumPorts)]) begin
                    o_winner = IdxWidth'((32'(i_rr) + k) % NumPorts);
                    o_valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/relobi_mux.sv
// Reliable-OBI N-to-1 multiplexer. Each of the three replicas arbitrates and
// tracks its own in-order response route; all control state is majority-voted
// before being stored. Define RELOBI_MUX_STICKY_FAULT_EN to get a sticky
// fault flag on fault_o[1]; otherwise that bit is tied low.
module relobi_mux import relobi_pkg::*; #(
    parameter obi_cfg_t    ObiCfg      = ObiDefaultConfig,
    parameter type         obi_req_t   = relobi_req_t,
    parameter type         obi_rsp_t   = relobi_rsp_t,
    parameter int unsigned NumSbrPorts = 2,
    parameter int unsigned NumMaxTrans = 4,
    parameter int unsigned IdxWidth    = idx_width(NumSbrPorts)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  obi_req_t [NumSbrPorts-1:0] sbr_ports_req_i,
    output obi_rsp_t [NumSbrPorts-1:0] sbr_ports_rsp_o,
    output obi_req_t                   mgr_port_req_o,
    input  obi_rsp_t                   mgr_port_rsp_i,
    output logic [FaultWidth-1:0]      fault_o
);

    if (ObiCfg.Integrity) begin : gen_err_integrity
        $fatal(1, "relobi_mux: ObiCfg.Integrity=1 is not supported");
    end
    if (NumSbrPorts < 2) begin : gen_err_ports
        $fatal(1, "relobi_mux: NumSbrPorts must be at least 2");
    end
    if (NumMaxTrans < 1) begin : gen_err_trans
        $fatal(1, "relobi_mux: NumMaxTrans must be at least 1");
    end

    localparam int unsigned PtrWidth = idx_width(NumMaxTrans);
    localparam int unsigned CntWidth = PtrWidth + 1;
    localparam int unsigned StWidth  = 2*IdxWidth + 1 + CntWidth + 2*PtrWidth;

    typedef logic [IdxWidth-1:0] route_t;

    function automatic route_t idx_inc(input route_t v);
        return (v == IdxWidth'(NumSbrPorts-1)) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] v);
        return (v == PtrWidth'(NumMaxTrans-1)) ? '0 : v + 1'b1;
    endfunction

    // Triplicated state
    logic [TmrWidth-1:0][IdxWidth-1:0]                  r_rr_q;
    logic [TmrWidth-1:0]                                r_lock_q;
    logic [TmrWidth-1:0][IdxWidth-1:0]                  r_lsel_q;
    logic [TmrWidth-1:0][CntWidth-1:0]                  r_cnt_q;
    logic [TmrWidth-1:0][PtrWidth-1:0]                  r_rd_q;
    logic [TmrWidth-1:0][PtrWidth-1:0]                  r_wr_q;
    logic [TmrWidth-1:0][NumMaxTrans-1:0][IdxWidth-1:0] r_mem_q;

    logic [TmrWidth-1:0][IdxWidth-1:0] w_win;
    logic [TmrWidth-1:0][IdxWidth-1:0] w_head;
    logic [TmrWidth-1:0]               w_wvld;
    logic [TmrWidth-1:0]               w_full;
    logic [TmrWidth-1:0]               w_nonempty;
    logic [TmrWidth-1:0]               w_mreq;
    logic [TmrWidth-1:0]               w_hs;
    logic [TmrWidth-1:0]               w_pop;
    logic [TmrWidth-1:0]               w_spur;
    logic [TmrWidth-1:0]               w_rready;
    logic [TmrWidth-1:0][StWidth-1:0]  w_st_n;

    logic [StWidth-1:0]  w_st_v;
    route_t              w_rr_v;
    logic                w_lock_v;
    route_t              w_lsel_v;
    logic [CntWidth-1:0] w_cnt_v;
    logic [PtrWidth-1:0] w_rd_v;
    logic [PtrWidth-1:0] w_wr_v;
    route_t              w_sel_v;
    logic                w_push_v;
    logic                w_vote_fault;
    logic                w_fault_now;

    for (genvar i = 0; i < TmrWidth; i++) begin : gen_rep
        logic [NumSbrPorts-1:0] w_cand;
        route_t                 w_rr_n;
        logic                   w_lock_n;
        route_t                 w_lsel_n;
        logic [CntWidth-1:0]    w_cnt_n;
        logic [PtrWidth-1:0]    w_rd_n;
        logic [PtrWidth-1:0]    w_wr_n;

        for (genvar p = 0; p < NumSbrPorts; p++) begin : gen_cand
            assign w_cand[p] = sbr_ports_req_i[p].req[i];
        end

        relobi_mux_rr_arb #(
            .NumPorts (NumSbrPorts),
            .IdxWidth (IdxWidth)
        ) i_arb (
            .i_req    (w_cand),
            .i_rr     (r_rr_q[i]),
            .i_lock   (r_lock_q[i]),
            .i_lsel   (r_lsel_q[i]),
            .o_winner (w_win[i]),
            .o_valid  (w_wvld[i])
        );

        assign w_nonempty[i] = (r_cnt_q[i] != '0);
        // No bypass: a full FIFO stalls even if a pop happens this cycle
        assign w_full[i]     = (r_cnt_q[i] == CntWidth'(NumMaxTrans));
        assign w_mreq[i]     = w_wvld[i] && !w_full[i];
        assign w_hs[i]       = w_mreq[i] && mgr_port_rsp_i.gnt[i];
        assign w_head[i]     = r_mem_q[i][r_rd_q[i]];

        if (ObiCfg.UseRReady) begin : gen_rready
            assign w_rready[i] = sbr_ports_req_i[w_head[i]].rready[i];
        end else begin : gen_no_rready
            assign w_rready[i] = 1'b1;
        end

        // A response with nothing outstanding is dropped and flagged
        assign w_spur[i] = mgr_port_rsp_i.rvalid[i] && !w_nonempty[i];
        assign w_pop[i]  = mgr_port_rsp_i.rvalid[i] && w_rready[i] && w_nonempty[i];

        assign w_rr_n   = w_hs[i] ? idx_inc(w_win[i]) : r_rr_q[i];
        assign w_lock_n = w_hs[i] ? 1'b0 : (w_mreq[i] ? 1'b1 : r_lock_q[i]);
        assign w_lsel_n = (w_mreq[i] && !mgr_port_rsp_i.gnt[i]) ? w_win[i] : r_lsel_q[i];
        assign w_cnt_n  = r_cnt_q[i] + CntWidth'(w_hs[i]) - CntWidth'(w_pop[i]);
        assign w_wr_n   = w_hs[i]  ? ptr_inc(r_wr_q[i]) : r_wr_q[i];
        assign w_rd_n   = w_pop[i] ? ptr_inc(r_rd_q[i]) : r_rd_q[i];

        assign w_st_n[i] = {w_rr_n, w_lock_n, w_lsel_n, w_cnt_n, w_rd_n, w_wr_n};
    end

    // Bitwise majority over all next-state fields, any disagreement is a fault
    assign w_st_v = (w_st_n[0] & w_st_n[1]) | (w_st_n[0] & w_st_n[2]) | (w_st_n[1] & w_st_n[2]);
    assign w_vote_fault = |((w_st_n[0] ^ w_st_n[1]) | (w_st_n[0] ^ w_st_n[2]));
    assign {w_rr_v, w_lock_v, w_lsel_v, w_cnt_v, w_rd_v, w_wr_v} = w_st_v;

    assign w_sel_v  = (w_win[0] & w_win[1]) | (w_win[0] & w_win[2]) | (w_win[1] & w_win[2]);
    assign w_push_v = (w_hs[0] & w_hs[1]) | (w_hs[0] & w_hs[2]) | (w_hs[1] & w_hs[2]);

    // Store the voted state into every replica; FIFO entries use the voted push
    // so a replica that missed a grant still holds the correct route
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_q   <= '0;
            r_lock_q <= '0;
            r_lsel_q <= '0;
            r_cnt_q  <= '0;
            r_rd_q   <= '0;
            r_wr_q   <= '0;
            r_mem_q  <= '0;
        end else begin
            for (int i = 0; i < TmrWidth; i++) begin
                r_rr_q[i]   <= w_rr_v;
                r_lock_q[i] <= w_lock_v;
                r_lsel_q[i] <= w_lsel_v;
                r_cnt_q[i]  <= w_cnt_v;
                r_rd_q[i]   <= w_rd_v;
                r_wr_q[i]   <= w_wr_v;
                if (w_push_v) begin
                    r_mem_q[i][r_wr_q[i]] <= w_sel_v;
                end
            end
        end
    end

    // Merged request towards the target
    always_comb begin
        mgr_port_req_o     = '0;
        mgr_port_req_o.req = w_mreq;
        mgr_port_req_o.a   = sbr_ports_req_i[w_sel_v].a;
        if (ObiCfg.UseRReady) begin
            mgr_port_req_o.rready = w_rready;
        end
    end

    // Per-port grant and response routing, r is broadcast
    always_comb begin
        for (int p = 0; p < NumSbrPorts; p++) begin
            sbr_ports_rsp_o[p]   = '0;
            sbr_ports_rsp_o[p].r = mgr_port_rsp_i.r;
            for (int i = 0; i < TmrWidth; i++) begin
                sbr_ports_rsp_o[p].gnt[i]    = mgr_port_rsp_i.gnt[i] && w_mreq[i] &&
                                               (w_win[i] == IdxWidth'(p));
                sbr_ports_rsp_o[p].rvalid[i] = mgr_port_rsp_i.rvalid[i] && w_nonempty[i] &&
                                               (w_head[i] == IdxWidth'(p));
            end
        end
    end

    assign w_fault_now       = w_vote_fault | (|w_spur);
    assign fault_o[FaultNow] = w_fault_now;

`ifdef RELOBI_MUX_STICKY_FAULT_EN
    logic r_fault_sticky;

    // Remember any fault until the next reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fault_sticky <= 1'b0;
        end else if (w_fault_now) begin
            r_fault_sticky <= 1'b1;
        end
    end

    assign fault_o[FaultSticky] = r_fault_sticky;
`else
    assign fault_o[FaultSticky] = 1'b0;
`endif

endmodule

// File: tb/tb_relobi_mux.sv
// Scoreboard bench for relobi_mux: stimulus queues expected grants/responses,
// a negedge monitor pops and compares whenever a subordinate sees gnt/rvalid.
module tb_relobi_mux;
    import relobi_pkg::*;

`ifdef RELOBI_MUX_STICKY_FAULT_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni;
    relobi_req_t [1:0] sbr_req;
    relobi_rsp_t [1:0] sbr_rsp;
    relobi_req_t       mgr_req;
    relobi_rsp_t       mgr_rsp;
    logic [1:0]        fault;

    always #5 clk_i = ~clk_i;

    relobi_mux #(
        .NumSbrPorts (2),
        .NumMaxTrans (4)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .sbr_ports_req_i (sbr_req),
        .sbr_ports_rsp_o (sbr_rsp),
        .mgr_port_req_o  (mgr_req),
        .mgr_port_rsp_i  (mgr_rsp),
        .fault_o         (fault)
    );

    typedef struct {
        int          port;
        logic [2:0]  vec;
        logic [31:0] data;
    } exp_t;

    exp_t q_gnt[$];
    exp_t q_rsp[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [31:0] addr_of(input int p);
        return 32'hA000_0000 + 32'(p);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_gnt(input int p, input logic [2:0] v);
        q_gnt.push_back('{port: p, vec: v, data: addr_of(p)});
    endtask

    task automatic push_rsp(input int p, input logic [31:0] d);
        q_rsp.push_back('{port: p, vec: 3'b111, data: d});
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            sbr_req[p]        = '0;
            sbr_req[p].rready = 3'b111;
            sbr_req[p].a.addr = addr_of(p);
        end
        mgr_rsp = '0;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every subordinate gnt/rvalid must match the head of its queue
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni) begin
            for (int p = 0; p < 2; p++) begin
                if (sbr_rsp[p].gnt != 3'b000) begin
                    if (q_gnt.size() == 0) begin
                        chk("unexpected_gnt", 64'(sbr_rsp[p].gnt), 64'd0);
                    end else begin
                        e = q_gnt.pop_front();
                        chk("gnt_port", 64'(p), 64'(e.port));
                        chk("gnt_vec", 64'(sbr_rsp[p].gnt), 64'(e.vec));
                        chk("gnt_addr", 64'(mgr_req.a.addr), 64'(e.data));
                    end
                end
                if (sbr_rsp[p].rvalid != 3'b000) begin
                    if (q_rsp.size() == 0) begin
                        chk("unexpected_rvalid", 64'(sbr_rsp[p].rvalid), 64'd0);
                    end else begin
                        e = q_rsp.pop_front();
                        chk("rsp_port", 64'(p), 64'(e.port));
                        chk("rsp_vec", 64'(sbr_rsp[p].rvalid), 64'(e.vec));
                        chk("rsp_data", 64'(sbr_rsp[p].r.rdata), 64'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        idle();
        repeat (2) @(posedge clk_i);
        mid();
        chk("rst_mgr_req", 64'(mgr_req.req), 64'd0);
        chk("rst_gnt0", 64'(sbr_rsp[0].gnt), 64'd0);
        chk("rst_gnt1", 64'(sbr_rsp[1].gnt), 64'd0);
        chk("rst_rvalid0", 64'(sbr_rsp[0].rvalid), 64'd0);
        chk("rst_rvalid1", 64'(sbr_rsp[1].rvalid), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        nxt();
        rst_ni = 1'b1;

        // Single port: grant same cycle, response two cycles later
        sbr_req[1].req = 3'b111;
        mgr_rsp.gnt    = 3'b111;
        push_gnt(1, 3'b111);
        mid();
        chk("t1_mgr_req", 64'(mgr_req.req), 64'h7);
        chk("t1_gnt0", 64'(sbr_rsp[0].gnt), 64'd0);
        nxt(); idle();
        mid(); nxt();
        mgr_rsp.rvalid     = 3'b111;
        mgr_rsp.r.rdata    = 32'h1111;
        push_rsp(1, 32'h1111);
        mid();
        chk("t1_rvalid0", 64'(sbr_rsp[0].rvalid), 64'd0);
        chk("t1_fault", 64'(fault[0]), 64'd0);
        nxt(); idle();

        // Fairness: both requesting, winners 0,1,0,1, responses one cycle behind
        for (int k = 0; k < 5; k++) begin
            sbr_req[0].req = (k < 4) ? 3'b111 : 3'b000;
            sbr_req[1].req = (k < 4) ? 3'b111 : 3'b000;
            mgr_rsp.gnt    = (k < 4) ? 3'b111 : 3'b000;
            if (k < 4) push_gnt(k % 2, 3'b111);
            if (k > 0) begin
                mgr_rsp.rvalid  = 3'b111;
                mgr_rsp.r.rdata = 32'h200 + 32'(k);
                push_rsp((k - 1) % 2, 32'h200 + 32'(k));
            end else begin
                mgr_rsp.rvalid = 3'b000;
            end
            mid();
            chk("fair_fault", 64'(fault[0]), 64'd0);
            nxt();
        end
        idle();

        // Move the pointer to port 1 with a port0 transaction
        sbr_req[0].req = 3'b111;
        mgr_rsp.gnt    = 3'b111;
        push_gnt(0, 3'b111);
        mid(); nxt(); idle();
        mgr_rsp.rvalid  = 3'b111;
        mgr_rsp.r.rdata = 32'h300;
        push_rsp(0, 32'h300);
        mid(); nxt(); idle();

        // Lock: port0 pending without gnt, port1 joins, address must hold
        for (int k = 0; k < 3; k++) begin
            sbr_req[0].req = 3'b111;
            sbr_req[1].req = (k > 0) ? 3'b111 : 3'b000;
            mid();
            chk("lock_addr", 64'(mgr_req.a.addr), 64'(addr_of(0)));
            chk("lock_req", 64'(mgr_req.req), 64'h7);
            nxt();
        end
        mgr_rsp.gnt = 3'b111;
        push_gnt(0, 3'b111);
        mid(); nxt();
        sbr_req[0].req = 3'b000;
        push_gnt(1, 3'b111);
        mid(); nxt(); idle();
        for (int k = 0; k < 2; k++) begin
            mgr_rsp.rvalid  = 3'b111;
            mgr_rsp.r.rdata = 32'h400 + 32'(k);
            push_rsp(k, 32'h400 + 32'(k));
            mid(); nxt();
        end
        idle();

        // Full: four grants fill the FIFO, fifth stalls even across a pop
        sbr_req[0].req = 3'b111;
        sbr_req[1].req = 3'b111;
        mgr_rsp.gnt    = 3'b111;
        for (int k = 0; k < 4; k++) begin
            push_gnt(k % 2, 3'b111);
            mid(); nxt();
        end
        mid();
        chk("full_req", 64'(mgr_req.req), 64'd0);
        chk("full_gnt0", 64'(sbr_rsp[0].gnt), 64'd0);
        chk("full_gnt1", 64'(sbr_rsp[1].gnt), 64'd0);
        nxt();
        mgr_rsp.rvalid  = 3'b111;
        mgr_rsp.r.rdata = 32'h500;
        push_rsp(0, 32'h500);
        mid();
        chk("full_req_pop", 64'(mgr_req.req), 64'd0);
        nxt();
        mgr_rsp.rvalid = 3'b000;
        push_gnt(0, 3'b111);
        mid();
        chk("full_regrant", 64'(mgr_req.req), 64'h7);
        nxt();
        idle();
        for (int k = 0; k < 4; k++) begin
            mgr_rsp.rvalid  = 3'b111;
            mgr_rsp.r.rdata = 32'h510 + 32'(k);
            push_rsp((k + 1) % 2, 32'h510 + 32'(k));
            mid(); nxt();
        end
        idle();

        // TMR fault: replica 2 misses the grant, voter repairs the state
        sbr_req[1].req = 3'b111;
        mgr_rsp.gnt    = 3'b011;
        push_gnt(1, 3'b011);
        mid();
        chk("tmr_fault_now", 64'(fault[0]), 64'd1);
        nxt(); idle();
        mid();
        chk("tmr_fault_clear", 64'(fault[0]), 64'd0);
        chk("tmr_sticky", 64'(fault[1]), 64'(STICKY));
        nxt();
        mgr_rsp.rvalid  = 3'b111;
        mgr_rsp.r.rdata = 32'h600;
        push_rsp(1, 32'h600);
        mid();
        chk("tmr_rsp_fault", 64'(fault[0]), 64'd0);
        nxt(); idle();

        // Spurious response with empty FIFO is dropped and flagged
        mgr_rsp.rvalid  = 3'b111;
        mgr_rsp.r.rdata = 32'h700;
        mid();
        chk("spur_fault", 64'(fault[0]), 64'd1);
        chk("spur_rvalid0", 64'(sbr_rsp[0].rvalid), 64'd0);
        chk("spur_rvalid1", 64'(sbr_rsp[1].rvalid), 64'd0);
        nxt(); idle();
        mid();
        chk("spur_clear", 64'(fault[0]), 64'd0);
        nxt();
        sbr_req[0].req = 3'b111;
        mgr_rsp.gnt    = 3'b111;
        push_gnt(0, 3'b111);
        mid();
        chk("post_spur_req", 64'(mgr_req.req), 64'h7);
        nxt(); idle();
        mgr_rsp.rvalid  = 3'b111;
        mgr_rsp.r.rdata = 32'h800;
        push_rsp(0, 32'h800);
        mid();
        chk("post_spur_fault", 64'(fault[0]), 64'd0);
        nxt(); idle();

        mid();
        chk("gnt_queue_empty", 64'(q_gnt.size()), 64'd0);
        chk("rsp_queue_empty", 64'(q_rsp.size()), 64'd0);
        chk("final_sticky", 64'(fault[1]), 64'(STICKY));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
